// File: rtl/detection_pkg.sv
// Shared types and width helpers for the ping-pong detection window buffer.
package detection_pkg;

  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_FILLING,
    BANK_READY,
    BANK_CLASSIFYING
  } bank_state_e;

  typedef enum logic {
    CONS_IDLE,
    CONS_RUN
  } cons_state_e;

  // Address width for n entries, never less than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fbram_sdp.sv
// Simple dual-port feature RAM: one write port, one registered read port.
module fbram_sdp
  import detection_pkg::*;
#(
  parameter  int unsigned DW    = 32,
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned RAW   = addr_w(DEPTH)
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic [RAW-1:0] waddr_i,
  input  logic [DW-1:0]  wdata_i,
  input  logic [RAW-1:0] raddr_i,
  output logic [DW-1:0]  rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/detection_window_ppbuf.sv
// N-bank ping-pong feature buffer between the Haar feature generator and the
// ANN classifier, with per-bank output-memory tags and a result register.
module detection_window_ppbuf
  import detection_pkg::*;
#(
  parameter  int unsigned FEAT_W  = 32,
  parameter  int unsigned N_FEAT  = 128,
  parameter  int unsigned N_BANKS = 2,
  parameter  int unsigned OM_AW   = 13,
  localparam int unsigned AW      = addr_w(N_FEAT),
  localparam int unsigned BW      = addr_w(N_BANKS)
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iWrreq_FBR,
  input  logic [AW-1:0]     iAddr_FBR,
  input  logic [FEAT_W-1:0] iFeature,
  input  logic              iLast,
  input  logic [OM_AW-1:0]  iAddr_OM,
  output logic              oReady_FBR,
  output logic              oFull_FBR,
  output logic              oOverrun,
  output logic              oStart_ANN,
  input  logic [AW-1:0]     iAddr_rd,
  output logic [FEAT_W-1:0] oFeature,
  input  logic              iDone_ANN,
  input  logic              iPass,
  input  logic [31:0]       iScore,
  output logic              oWrreq_OM,
  output logic [OM_AW-1:0]  oAddr_OM,
  output logic [31:0]       oData_out,
  output logic              oPass,
  output logic              oBusy
);

  bank_state_e      bank_q [N_BANKS];
  bank_state_e      bank_d [N_BANKS];
  logic [OM_AW-1:0] tag_q  [N_BANKS];
  logic [OM_AW-1:0] tag_d  [N_BANKS];
  logic [BW-1:0]    wp_q, wp_d, rp_q, rp_d;
  cons_state_e      cons_q, cons_d;

  logic             start_q, start_d;
  logic             wrreq_q, wrreq_d;
  logic [OM_AW-1:0] addr_om_q, addr_om_d;
  logic [31:0]      data_q, data_d;
  logic             pass_q, pass_d;
  logic             overrun_q, overrun_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic wr_ok, wr_en, commit;

  function automatic logic [BW-1:0] next_ptr(input logic [BW-1:0] p);
    return (p == BW'(N_BANKS - 1)) ? '0 : p + BW'(1);
  endfunction

  assign wr_ok  = (bank_q[wp_q] == BANK_FREE) || (bank_q[wp_q] == BANK_FILLING);
  assign wr_en  = iWrreq_FBR && wr_ok;
  assign commit = wr_en && iLast;

  always_comb begin
    bank_d    = bank_q;
    tag_d     = tag_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    cons_d    = cons_q;
    start_d   = 1'b0;
    wrreq_d   = 1'b0;
    addr_om_d = addr_om_q;
    data_d    = data_q;
    pass_d    = pass_q;
    overrun_d = overrun_q | (iWrreq_FBR & ~wr_ok);

    if (wr_en) begin
      bank_d[wp_q] = BANK_FILLING;
      if (iLast) begin
        bank_d[wp_q] = BANK_READY;
        tag_d[wp_q]  = iAddr_OM;
        wp_d         = next_ptr(wp_q);
      end
    end

    // An idle consumer also claims a bank committed on this very edge so the
    // start pulse follows iLast by one cycle.
    case (cons_q)
      CONS_IDLE: begin
        if ((bank_q[rp_q] == BANK_READY) || (commit && (wp_q == rp_q))) begin
          bank_d[rp_q] = BANK_CLASSIFYING;
          start_d      = 1'b1;
          cons_d       = CONS_RUN;
        end
      end
      CONS_RUN: begin
        if (iDone_ANN) begin
          bank_d[rp_q] = BANK_FREE;
          rp_d         = next_ptr(rp_q);
          wrreq_d      = 1'b1;
          addr_om_d    = tag_q[rp_q];
          data_d       = iScore;
          pass_d       = iPass;
          cons_d       = CONS_IDLE;
        end
      end
      default: cons_d = CONS_IDLE;
    endcase

    ready_d = (bank_d[wp_d] == BANK_FREE) || (bank_d[wp_d] == BANK_FILLING);
    busy_d  = (cons_d != CONS_IDLE);
    for (int unsigned i = 0; i < N_BANKS; i++) begin
      if (bank_d[i] != BANK_FREE) busy_d = 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      for (int unsigned i = 0; i < N_BANKS; i++) begin
        bank_q[i] <= BANK_FREE;
        tag_q[i]  <= '0;
      end
      wp_q      <= '0;
      rp_q      <= '0;
      cons_q    <= CONS_IDLE;
      start_q   <= 1'b0;
      wrreq_q   <= 1'b0;
      addr_om_q <= '0;
      data_q    <= '0;
      pass_q    <= 1'b0;
      overrun_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      tag_q     <= tag_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cons_q    <= cons_d;
      start_q   <= start_d;
      wrreq_q   <= wrreq_d;
      addr_om_q <= addr_om_d;
      data_q    <= data_d;
      pass_q    <= pass_d;
      overrun_q <= overrun_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  fbram_sdp #(
    .DW    (FEAT_W),
    .DEPTH (N_BANKS * N_FEAT)
  ) u_fbram (
    .clk_i   (iClk),
    .we_i    (wr_en),
    .waddr_i ({wp_q, iAddr_FBR}),
    .wdata_i (iFeature),
    .raddr_i ({rp_q, iAddr_rd}),
    .rdata_o (oFeature)
  );

  assign oReady_FBR = ready_q;
  assign oFull_FBR  = ~ready_q;
  assign oOverrun   = overrun_q;
  assign oStart_ANN = start_q;
  assign oWrreq_OM  = wrreq_q;
  assign oAddr_OM   = addr_om_q;
  assign oData_out  = data_q;
  assign oPass      = pass_q;
  assign oBusy      = busy_q;

endmodule

// File: tb/tb_detection_window_ppbuf.sv
// Directed bench for the ping-pong detection window buffer (N_BANKS=2).
module tb_detection_window_ppbuf;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iWrreq_FBR;
  logic [6:0]  iAddr_FBR;
  logic [31:0] iFeature;
  logic        iLast;
  logic [12:0] iAddr_OM;
  logic        oReady_FBR, oFull_FBR, oOverrun, oStart_ANN;
  logic [6:0]  iAddr_rd;
  logic [31:0] oFeature;
  logic        iDone_ANN, iPass;
  logic [31:0] iScore;
  logic        oWrreq_OM;
  logic [12:0] oAddr_OM;
  logic [31:0] oData_out;
  logic        oPass, oBusy;

  int tests = 0;
  int fails = 0;

  always #5 iClk = ~iClk;

  detection_window_ppbuf #(
    .FEAT_W  (32),
    .N_FEAT  (128),
    .N_BANKS (2),
    .OM_AW   (13)
  ) dut (
    .iClk       (iClk),
    .iReset     (iReset),
    .iWrreq_FBR (iWrreq_FBR),
    .iAddr_FBR  (iAddr_FBR),
    .iFeature   (iFeature),
    .iLast      (iLast),
    .iAddr_OM   (iAddr_OM),
    .oReady_FBR (oReady_FBR),
    .oFull_FBR  (oFull_FBR),
    .oOverrun   (oOverrun),
    .oStart_ANN (oStart_ANN),
    .iAddr_rd   (iAddr_rd),
    .oFeature   (oFeature),
    .iDone_ANN  (iDone_ANN),
    .iPass      (iPass),
    .iScore     (iScore),
    .oWrreq_OM  (oWrreq_OM),
    .oAddr_OM   (oAddr_OM),
    .oData_out  (oData_out),
    .oPass      (oPass),
    .oBusy      (oBusy)
  );

  typedef struct {
    logic [31:0] base;
    logic [12:0] tag;
    logic [31:0] score;
    logic        pass;
    logic [6:0]  rd_addr;
    logic [31:0] exp_feat;
  } win_t;

  win_t wins [3];

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ready"},   32'(oReady_FBR), 32'd1);
    chk({tag, " full"},    32'(oFull_FBR),  32'd0);
    chk({tag, " overrun"}, 32'(oOverrun),   32'd0);
    chk({tag, " start"},   32'(oStart_ANN), 32'd0);
    chk({tag, " wrreq"},   32'(oWrreq_OM),  32'd0);
    chk({tag, " addr_om"}, 32'(oAddr_OM),   32'd0);
    chk({tag, " data"},    oData_out,       32'd0);
    chk({tag, " pass"},    32'(oPass),      32'd0);
    chk({tag, " busy"},    32'(oBusy),      32'd0);
  endtask

  task automatic do_reset();
    iReset = 1'b1;
    step();
    step();
    iReset = 1'b0;
    step();
  endtask

  // Writes features base+addr for addr 0..n-1; iLast on the final one if last.
  task automatic fill(input logic [31:0] base, input logic [12:0] tag, input int n, input bit last);
    for (int a = 0; a < n; a++) begin
      iWrreq_FBR = 1'b1;
      iAddr_FBR  = 7'(a);
      iFeature   = base + 32'(a);
      iLast      = last && (a == n - 1);
      iAddr_OM   = tag;
      step();
    end
    iWrreq_FBR = 1'b0;
    iLast      = 1'b0;
  endtask

  task automatic done(input logic [31:0] score, input logic pass);
    iDone_ANN = 1'b1;
    iScore    = score;
    iPass     = pass;
    step();
    iDone_ANN = 1'b0;
  endtask

  initial begin
    wins[0] = '{32'h1000_0000, 13'h0123, 32'hA5A5_0001, 1'b1, 7'd9,   32'h1000_0009};
    wins[1] = '{32'h2000_0100, 13'h1FFF, 32'h0000_0000, 1'b0, 7'd127, 32'h2000_017F};
    wins[2] = '{32'hFFFF_FF80, 13'h0ABC, 32'hFFFF_FFFF, 1'b1, 7'd64,  32'hFFFF_FFC0};

    iReset = 1'b1; iWrreq_FBR = 1'b0; iAddr_FBR = '0; iFeature = '0; iLast = 1'b0;
    iAddr_OM = '0; iAddr_rd = '0; iDone_ANN = 1'b0; iPass = 1'b0; iScore = '0;
    step();
    chk_reset_outputs("reset");
    iReset = 1'b0;
    step();

    // First window: data = address, tag 0x0A5.
    fill(32'd0, 13'h0A5, 128, 1'b1);
    chk("w0 start after iLast", 32'(oStart_ANN), 32'd1);
    chk("w0 busy", 32'(oBusy), 32'd1);
    chk("w0 ready (bank1 free)", 32'(oReady_FBR), 32'd1);
    iAddr_rd = 7'd5;
    step();
    chk("w0 start one cycle", 32'(oStart_ANN), 32'd0);
    chk("w0 read addr5", oFeature, 32'd5);
    done(32'h1234_5678, 1'b1);
    chk("w0 om wrreq", 32'(oWrreq_OM), 32'd1);
    chk("w0 om addr",  32'(oAddr_OM),  32'h0A5);
    chk("w0 om data",  oData_out,      32'h1234_5678);
    chk("w0 om pass",  32'(oPass),     32'd1);
    chk("w0 idle busy", 32'(oBusy),    32'd0);
    step();
    chk("w0 wrreq one cycle", 32'(oWrreq_OM), 32'd0);

    // Stray done while idle.
    done(32'hDEAD_BEEF, 1'b0);
    chk("stray wrreq", 32'(oWrreq_OM), 32'd0);
    chk("stray busy",  32'(oBusy),     32'd0);
    chk("stray data held", oData_out,  32'h1234_5678);
    chk("stray ready", 32'(oReady_FBR), 32'd1);

    // Table of windows, alternating banks.
    for (int w = 0; w < 3; w++) begin
      fill(wins[w].base, wins[w].tag, 128, 1'b1);
      chk($sformatf("tbl%0d start", w), 32'(oStart_ANN), 32'd1);
      iAddr_rd = wins[w].rd_addr;
      step();
      chk($sformatf("tbl%0d feature", w), oFeature, wins[w].exp_feat);
      done(wins[w].score, wins[w].pass);
      chk($sformatf("tbl%0d wrreq", w), 32'(oWrreq_OM), 32'd1);
      chk($sformatf("tbl%0d addr", w),  32'(oAddr_OM),  32'(wins[w].tag));
      chk($sformatf("tbl%0d data", w),  oData_out,      wins[w].score);
      chk($sformatf("tbl%0d pass", w),  32'(oPass),     32'(wins[w].pass));
      step();
    end

    // Consumer stalled: both banks committed, third write overruns.
    do_reset();
    fill(32'h0000_0100, 13'h011, 128, 1'b1);
    chk("stall full after 1st", 32'(oFull_FBR), 32'd0);
    fill(32'h0000_0200, 13'h022, 128, 1'b1);
    chk("stall full after 2nd", 32'(oFull_FBR), 32'd1);
    chk("stall ready after 2nd", 32'(oReady_FBR), 32'd0);
    chk("stall no overrun yet", 32'(oOverrun), 32'd0);
    iWrreq_FBR = 1'b1; iAddr_FBR = 7'd5; iFeature = 32'hDEAD_0005;
    step();
    iWrreq_FBR = 1'b0;
    chk("stall overrun set", 32'(oOverrun), 32'd1);
    iAddr_rd = 7'd5;
    step();
    chk("stall bank0 intact", oFeature, 32'h0000_0105);
    chk("stall overrun sticky", 32'(oOverrun), 32'd1);

    // iLast on bank 1 coincides with iDone on bank 0.
    do_reset();
    fill(32'h0000_0100, 13'h011, 128, 1'b1);
    fill(32'h0000_0300, 13'h033, 127, 1'b0);
    iWrreq_FBR = 1'b1; iAddr_FBR = 7'd127; iFeature = 32'h0000_037F;
    iLast = 1'b1; iAddr_OM = 13'h033;
    iDone_ANN = 1'b1; iScore = 32'hCAFE_0001; iPass = 1'b0;
    step();
    iWrreq_FBR = 1'b0; iLast = 1'b0; iDone_ANN = 1'b0;
    chk("sim om wrreq", 32'(oWrreq_OM), 32'd1);
    chk("sim om addr",  32'(oAddr_OM),  32'h011);
    chk("sim om data",  oData_out,      32'hCAFE_0001);
    chk("sim om pass",  32'(oPass),     32'd0);
    chk("sim full +1",  32'(oFull_FBR), 32'd0);
    chk("sim no start +1", 32'(oStart_ANN), 32'd0);
    iAddr_rd = 7'd7;
    step();
    chk("sim start +2", 32'(oStart_ANN), 32'd1);
    chk("sim full +2",  32'(oFull_FBR),  32'd0);
    step();
    chk("sim bank1 read", oFeature, 32'h0000_0307);
    done(32'h0BAD_F00D, 1'b1);
    chk("sim bank1 om addr", 32'(oAddr_OM), 32'h033);

    // Asynchronous reset mid-fill.
    step();
    fill(32'h0000_0500, 13'h055, 10, 1'b0);
    chk("midfill busy before", 32'(oBusy), 32'd1);
    #2 iReset = 1'b1;
    #1;
    chk_reset_outputs("midfill async");
    step();
    iReset = 1'b0;
    step();

    // Asynchronous reset mid-classify.
    fill(32'h0000_0600, 13'h066, 128, 1'b1);
    chk("midcls start", 32'(oStart_ANN), 32'd1);
    step();
    #2 iReset = 1'b1;
    #1;
    chk_reset_outputs("midcls async");
    step();
    iReset = 1'b0;
    step();

    // Recovery window completes normally.
    fill(32'h0000_0700, 13'h077, 128, 1'b1);
    chk("recover start", 32'(oStart_ANN), 32'd1);
    chk("recover ready", 32'(oReady_FBR), 32'd1);
    iAddr_rd = 7'd100;
    step();
    chk("recover read", oFeature, 32'h0000_0764);
    done(32'h7777_0000, 1'b1);
    chk("recover om wrreq", 32'(oWrreq_OM), 32'd1);
    chk("recover om addr",  32'(oAddr_OM),  32'h077);
    chk("recover om data",  oData_out,      32'h7777_0000);
    chk("recover busy",     32'(oBusy),     32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/detection_window_ppbuf.md
# detection_window_ppbuf

Parametrised successor of the single-window detection stage. It decouples Haar feature generation from ANN classification through an N-bank ping-pong feature buffer, so the generator fills bank k+1 while the classifier reads bank k. Each bank carries its output-memory address tag. When classification completes, the block writes one result word per window to the output memory. It sits between the integral-image/HFG front end and the output memory, replacing the single-bank feature BRAM hookup.

## Interface
- FEAT_W, 32, feature word width
- N_FEAT, 128, feature words per window (bank depth); AW = clog2(N_FEAT)
- N_BANKS, 2, number of feature banks (2..4); BW = clog2(N_BANKS), min 1
- OM_AW, 13, output-memory address width
- iClk  in  1  clock, rising edge
- iReset  in  1  asynchronous, active-high reset
- iWrreq_FBR  in  1  producer feature write strobe
- iAddr_FBR  in  AW  producer write address within current bank
- iFeature  in  FEAT_W  producer feature data
- iLast  in  1  with iWrreq_FBR: final feature of window, commits bank
- iAddr_OM  in  OM_AW  window tag, sampled with iLast
- oReady_FBR  out  1  a bank is FILLING/available for writes
- oFull_FBR  out  1  no bank free (= !oReady_FBR)
- oOverrun  out  1  sticky: write attempted while oReady_FBR low
- oStart_ANN  out  1  one-cycle pulse: bank ready for classifier
- iAddr_rd  in  AW  classifier read address in current read bank
- oFeature  out  FEAT_W  read data, 1-cycle latency
- iDone_ANN  in  1  classifier finished current bank
- iPass  in  1  classifier verdict, valid with iDone_ANN
- iScore  in  32  classifier output word, valid with iDone_ANN
- oWrreq_OM  out  1  output-memory write pulse
- oAddr_OM  out  OM_AW  tag of the classified window
- oData_out  out  32  registered iScore
- oPass  out  1  registered iPass
- oBusy  out  1  any bank not FREE or consumer not IDLE

## Operation
- Per-bank state: FREE → FILLING → READY → CLASSIFYING → FREE. Write pointer wp, read pointer rp, both wrap modulo N_BANKS.
- Reset: all banks FREE, wp=rp=0. Outputs: oReady_FBR=1, oFull_FBR=0, oOverrun=0, oStart_ANN=0, oWrreq_OM=0, oAddr_OM=0, oData_out=0, oPass=0, oBusy=0. oFeature is undefined until the first read.
- Write path:
  - iWrreq_FBR while bank[wp] is FREE/FILLING: write RAM[{wp,iAddr_FBR}], bank becomes FILLING.
  - With iLast: bank → READY, tag[wp] ← iAddr_OM, wp advances.
  - Write while the target bank is READY/CLASSIFYING: dropped, oOverrun set.
- Consumer FSM IDLE → RUN → IDLE:
  - IDLE and bank[rp]==READY: pulse oStart_ANN, bank → CLASSIFYING, enter RUN.
  - RUN: reads address {rp,iAddr_rd}.
  - iDone_ANN in RUN: bank → FREE, rp advances, result registered, return to IDLE.
- iDone_ANN in IDLE is ignored; no OM write.
- Simultaneous iLast on bank wp and iDone_ANN on bank rp: both take effect in the same cycle, since the banks differ.
- Reset mid-window discards all bank contents and tags.

## Timing
- Write at edge t is readable from edge t+1 (RAM in write-first/don't-care; same-bank read/write is impossible by construction).
- iLast at edge t: bank READY at t+1. oStart_ANN is high during cycle t+1 if the consumer is IDLE.
- oStart_ANN → first valid iAddr_rd is the next cycle; oFeature is valid 1 cycle after iAddr_rd.
- iDone_ANN at edge t: oWrreq_OM, oAddr_OM, oData_out and oPass are valid in cycle t+1, one-cycle pulse.
  - The next oStart_ANN is no earlier than cycle t+2.
- oReady_FBR/oFull_FBR update the cycle after the bank state changes. Freeing a bank raises oReady_FBR at t+1.
- Back-to-back steady state: one window per max(N_FEAT write cycles, classifier run + 2) cycles.

## Structure
- Package detection_pkg: bank state enum (FREE, FILLING, READY, CLASSIFYING), consumer state enum, width helper functions.
- Sub-module fbram_sdp: parametrised simple dual-port RAM with depth N_BANKS*N_FEAT, registered read. Everything else (bank table, pointers, FSM, result register) lives in the top.

## Test plan
- Reset, then write 128 features (data = address) to bank 0 with iLast at addr 127, tag 0x0A5:
  - oStart_ANN pulses 1 cycle after iLast.
  - Read addr 5 returns 5 one cycle later.
- Classifier done with iScore=0x1234_5678, iPass=1:
  - Next cycle oWrreq_OM=1, oAddr_OM=0x0A5, oData_out=0x12345678, oPass=1.
  - Bank 0 returns to FREE.
- N_BANKS=2, consumer stalled: fill banks 0 and 1.
  - oFull_FBR=1 after the second iLast.
  - A third write sets oOverrun=1 and leaves the bank 0 data intact.
- iLast on bank 1 and iDone_ANN on bank 0 in the same cycle:
  - OM write for bank 0.
  - oStart_ANN for bank 1 at +2.
  - oFull_FBR stays 0.
- Assert iReset mid-fill and mid-classify:
  - All outputs return to reset values asynchronously.
  - A subsequent window completes normally with wp=rp=0.
- Stray iDone_ANN while IDLE: no oWrreq_OM, state unchanged.
